// File: rtl/kf_interrupt_request_array.sv
// Interrupt-request front end: per-pin synchroniser, glitch filter, arm latch and IRR.
// Define KF_IRQ_EDGE_COUNT_EN to queue edge-mode requests that arrive while one is latched.
module kf_interrupt_request_array #(
  parameter int NUM_IRQ       = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int PEND_WIDTH    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] level_or_edge_triggered_config,
  input  logic               freeze,
  input  logic [NUM_IRQ-1:0] clear_interrupt_request,
  input  logic [NUM_IRQ-1:0] interrupt_request_pin,
  output logic [NUM_IRQ-1:0] interrupt_request_register,
  output logic [NUM_IRQ-1:0] filtered_request
);

  // Cycles after reset before the filter output reflects the real pin level.
  localparam int WARM = SYNC_STAGES + FILTER_CYCLES;
  localparam int WW   = $clog2(WARM + 1);

  generate
    if (NUM_IRQ < 1 || NUM_IRQ > 32 || SYNC_STAGES < 1 || FILTER_CYCLES < 0 || PEND_WIDTH < 1) begin : g_bad_params
      $error("kf_interrupt_request_array: illegal parameter value");
    end
  endgenerate

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
  logic [NUM_IRQ-1:0] sync_out, filt, edge_det;
  logic [NUM_IRQ-1:0] arm_q, arm_d, irr_q, irr_d;
  logic [WW-1:0]      warm_q, warm_d;
  logic               primed;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = interrupt_request_pin;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_no_filter
      assign filt = sync_out;
    end else begin : g_filter
      localparam int CW = $clog2(FILTER_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
      logic [NUM_IRQ-1:0][CW-1:0] cnt_q, cnt_d;
      logic [NUM_IRQ-1:0]         filt_q, filt_d;

      always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (sync_out[i] == filt_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == LAST) begin
            filt_d[i] = sync_out[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_q  <= '0;
          filt_q <= '0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign filt = filt_q;
    end
  endgenerate

  // Arming waits for the pipeline to fill so a pin held high across reset is not mistaken for low.
  assign primed   = (warm_q == WW'(WARM));
  assign warm_d   = primed ? warm_q : warm_q + 1'b1;
  assign edge_det = arm_q & filt;

`ifdef KF_IRQ_EDGE_COUNT_EN
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  logic [NUM_IRQ-1:0]                 filt_prev_q;
  logic [NUM_IRQ-1:0][PEND_WIDTH-1:0] pend_q, pend_d;
`endif

  always_comb begin
    arm_d = arm_q;
    irr_d = irr_q;
`ifdef KF_IRQ_EDGE_COUNT_EN
    pend_d = pend_q;
`endif
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (clear_interrupt_request[i]) begin
        arm_d[i] = 1'b0;
      end else if (primed && !filt[i]) begin
        arm_d[i] = 1'b1;
      end

      if (clear_interrupt_request[i]) begin
        irr_d[i] = 1'b0;
      end else if (freeze) begin
        irr_d[i] = irr_q[i];
      end else if (level_or_edge_triggered_config[i]) begin
        irr_d[i] = filt[i];
      end else begin
`ifdef KF_IRQ_EDGE_COUNT_EN
        // Queued edges are replayed one at a time; a latched edge request stays until cleared.
        if (!irr_q[i] && pend_q[i] != '0) begin
          irr_d[i]  = 1'b1;
          pend_d[i] = pend_q[i] - 1'b1;
        end else begin
          irr_d[i] = irr_q[i] | edge_det[i];
        end
`else
        irr_d[i] = edge_det[i];
`endif
      end

`ifdef KF_IRQ_EDGE_COUNT_EN
      if (level_or_edge_triggered_config[i]) begin
        pend_d[i] = '0;
      end else if (filt[i] && !filt_prev_q[i] && (irr_q[i] || freeze) && pend_q[i] != PEND_MAX) begin
        pend_d[i] = pend_q[i] + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      warm_q <= '0;
      arm_q  <= '0;
      irr_q  <= '0;
`ifdef KF_IRQ_EDGE_COUNT_EN
      filt_prev_q <= '0;
      pend_q      <= '0;
`endif
    end else begin
      sync_q <= sync_d;
      warm_q <= warm_d;
      arm_q  <= arm_d;
      irr_q  <= irr_d;
`ifdef KF_IRQ_EDGE_COUNT_EN
      filt_prev_q <= filt;
      pend_q      <= pend_d;
`endif
    end
  end

  assign interrupt_request_register = irr_q;
  assign filtered_request           = filt;

endmodule

// File: tb/tb_kf_interrupt_request_array.sv
// Directed bench for kf_interrupt_request_array at default parameters (edge-count option off).
module tb_kf_interrupt_request_array;

  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         freeze;
  logic [N-1:0] cfg;
  logic [N-1:0] clr;
  logic [N-1:0] pins;
  logic [N-1:0] irr;
  logic [N-1:0] filt;
  int           checks = 0;
  int           errors = 0;

  always #5 clock = ~clock;

  kf_interrupt_request_array dut (
    .clock                          (clock),
    .reset                          (reset),
    .level_or_edge_triggered_config (cfg),
    .freeze                         (freeze),
    .clear_interrupt_request        (clr),
    .interrupt_request_pin          (pins),
    .interrupt_request_register     (irr),
    .filtered_request               (filt)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic [N-1:0] p, input logic [N-1:0] c,
                                input logic f, input logic [N-1:0] cl);
    pins   = p;
    cfg    = c;
    freeze = f;
    clr    = cl;
  endtask

  task automatic check_output(input string tag, input logic [N-1:0] observed,
                              input logic [N-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    // Pins high through reset: filter follows the pin, but no edge request may appear.
    reset = 1'b1;
    apply_stimulus(8'hFF, 8'h00, 1'b0, 8'h00);
    tick(3);
    check_output("reset_irr", irr, 8'h00);
    check_output("reset_filt", filt, 8'h00);
    reset = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick(1);
      check_output($sformatf("hi_at_reset_irr_%0d", k), irr, 8'h00);
      check_output($sformatf("hi_at_reset_filt_%0d", k), filt, (k >= 5) ? 8'hFF : 8'h00);
    end

    // All pins low long enough to arm every channel.
    apply_stimulus(8'h00, 8'h00, 1'b0, 8'h00);
    tick(10);
    check_output("low_irr", irr, 8'h00);
    check_output("low_filt", filt, 8'h00);

    // Clean edge on ch0: six-edge latency, then clear while the pin stays high.
    apply_stimulus(8'h01, 8'h00, 1'b0, 8'h00);
    tick(5);
    check_output("ch0_edge_t5_irr", irr, 8'h00);
    check_output("ch0_edge_t5_filt", filt, 8'h01);
    tick(1);
    check_output("ch0_edge_t6_irr", irr, 8'h01);
    tick(5);
    check_output("ch0_edge_hold_irr", irr, 8'h01);
    apply_stimulus(8'h01, 8'h00, 1'b0, 8'h01);
    tick(1);
    apply_stimulus(8'h01, 8'h00, 1'b0, 8'h00);
    check_output("ch0_clear_irr", irr, 8'h00);
    tick(5);
    check_output("ch0_clear_stays_irr", irr, 8'h00);

    // Two-cycle glitch on ch3 is dropped entirely.
    apply_stimulus(8'h09, 8'h00, 1'b0, 8'h00);
    tick(2);
    apply_stimulus(8'h01, 8'h00, 1'b0, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check_output($sformatf("glitch2_filt_%0d", k), filt, 8'h01);
      check_output($sformatf("glitch2_irr_%0d", k), irr, 8'h00);
    end

    // Three-cycle pulse on ch3 is just long enough to be accepted.
    apply_stimulus(8'h09, 8'h00, 1'b0, 8'h00);
    tick(3);
    apply_stimulus(8'h01, 8'h00, 1'b0, 8'h00);
    tick(2);
    check_output("pulse3_t5_filt", filt, 8'h09);
    check_output("pulse3_t5_irr", irr, 8'h00);
    tick(1);
    check_output("pulse3_t6_irr", irr, 8'h08);
    tick(10);
    check_output("pulse3_gone_irr", irr, 8'h00);

    // Level mode on ch5: follows filtered pin, and a clear only lasts one cycle.
    apply_stimulus(8'h21, 8'h20, 1'b0, 8'h00);
    tick(5);
    check_output("lvl_rise_t5_irr", irr, 8'h00);
    tick(1);
    check_output("lvl_rise_t6_irr", irr, 8'h20);
    apply_stimulus(8'h21, 8'h20, 1'b0, 8'h20);
    tick(1);
    apply_stimulus(8'h21, 8'h20, 1'b0, 8'h00);
    check_output("lvl_clear_irr", irr, 8'h00);
    tick(1);
    check_output("lvl_reassert_irr", irr, 8'h20);
    tick(12);
    apply_stimulus(8'h01, 8'h20, 1'b0, 8'h00);
    tick(5);
    check_output("lvl_fall_t5_irr", irr, 8'h20);
    tick(1);
    check_output("lvl_fall_t6_irr", irr, 8'h00);
    apply_stimulus(8'h01, 8'h00, 1'b0, 8'h00);
    tick(2);

    // Freeze holds IRR over an edge on ch1; release picks it up next cycle.
    apply_stimulus(8'h03, 8'h00, 1'b1, 8'h00);
    tick(9);
    check_output("freeze_hold_irr", irr, 8'h00);
    apply_stimulus(8'h03, 8'h00, 1'b0, 8'h00);
    tick(1);
    check_output("freeze_release_irr", irr, 8'h02);

    // Clear beats freeze on latched ch2.
    apply_stimulus(8'h07, 8'h00, 1'b0, 8'h00);
    tick(6);
    check_output("ch2_latched_irr", irr, 8'h06);
    apply_stimulus(8'h07, 8'h00, 1'b1, 8'h04);
    tick(1);
    check_output("clear_vs_freeze_irr", irr, 8'h02);
    apply_stimulus(8'h07, 8'h00, 1'b0, 8'h00);
    tick(3);
    check_output("ch2_stays_clear_irr", irr, 8'h02);

    // Reset mid-filter on ch4 discards the partial count and everything latched.
    apply_stimulus(8'h17, 8'h00, 1'b0, 8'h00);
    tick(4);
    reset = 1'b1;
    tick(1);
    check_output("midfilter_reset_irr", irr, 8'h00);
    check_output("midfilter_reset_filt", filt, 8'h00);
    reset = 1'b0;
    tick(10);
    check_output("post_reset_filt", filt, 8'h17);
    check_output("post_reset_irr", irr, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
